// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port mem data-port arbiter: FSM encodings and port ids.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic [1:0] own_state(input logic port);
    return (port == PORT_CPU) ? ST_OWN0 : ST_OWN1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// Beat counter for the current owner; at_limit marks the last beat of a contended burst.
module burst_counter #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == LIMIT);

  // Wrapping at the limit keeps an uncontended owner granted indefinitely.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (inc) cnt_d = at_limit ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the mem data port between the CPU (port 0) and DMA (port 1),
// with bounded bursts under contention and zero-bubble handover.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       cnt_clear, cnt_inc, at_limit;

  burst_counter #(.MAX_BURST(MAX_BURST)) u_burst_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b1;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = own_state(~owner_q);
        else if (req0)     state_d = ST_OWN0;
        else if (req1)     state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (req0) begin
          if (at_limit && req1) state_d = ST_OWN1;
          else begin
            cnt_clear = 1'b0;
            cnt_inc   = 1'b1;
          end
        end else begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (req1) begin
          if (at_limit && req0) state_d = ST_OWN0;
          else begin
            cnt_clear = 1'b0;
            cnt_inc   = 1'b1;
          end
        end else begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    if (state_d == ST_OWN0)      owner_d = PORT_CPU;
    else if (state_d == ST_OWN1) owner_d = PORT_DMA;
  end

  // Reset owner to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_DMA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign gnt0  = (state_q == ST_OWN0);
  assign gnt1  = (state_q == ST_OWN1);
  assign ack0  = gnt0 & req0;
  assign ack1  = gnt1 & req1;
  assign owner = owner_q;

  // Port 0 drives the bus while idle; mem_we is qualified by ack so aborts never write.
  assign mem_addr = gnt1 ? addr1 : addr0;
  assign mem_wd   = gnt1 ? wd1   : wd0;
  assign mem_we   = (ack0 & we0) | (ack1 & we1);
  assign rdata    = mem_rd;

endmodule
